// File: rtl/log_readout_sequencer.sv
// log_readout_sequencer: starts one RAM log capture per host command, waits the capture window,
// then reads len words back from the RAM and streams them over valid/ready.
// Ports: clk/i_reset (async, active-low); i_cmd_valid/o_cmd_ready/i_cmd_sel/i_cmd_len command;
// i_abort cancels a running command; o_data_sel_for_log/o_en_write/o_en_read/o_read_adrs drive
// the logger; i_ram_data is RAM read data; o_data/o_valid/i_ready stream out;
// o_busy/o_done/o_err report status.
module log_readout_sequencer #(
    parameter int RAM_WIDTH    = 32,
    parameter int RAM_DEPTH    = 32768,
    parameter int READ_LATENCY = 1,
    parameter int CAPTURE_WAIT = 1048576,
    localparam int ADDR_W      = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [2:0]           i_cmd_sel,
    input  logic [ADDR_W:0]      i_cmd_len,
    input  logic                 i_abort,
    output logic [2:0]           o_data_sel_for_log,
    output logic                 o_en_write,
    output logic                 o_en_read,
    output logic [ADDR_W-1:0]    o_read_adrs,
    input  logic [RAM_WIDTH-1:0] i_ram_data,
    output logic [RAM_WIDTH-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);
    localparam int CNT_W = $clog2(CAPTURE_WAIT + READ_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(CAPTURE_WAIT - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(RAM_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_READ, S_WAIT, S_OUT, S_DONE} state_t;

    state_t              state, nxt;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     len_q;
    logic [2:0]          sel_q;
    logic                err_q, rd_q;
    logic                cmd_bad, accept, abort_hit, last;

    always_comb begin
        cmd_bad   = i_cmd_sel == 3'd0 || i_cmd_sel > 3'd3 || i_cmd_len == '0;
        accept    = state == S_IDLE && i_cmd_valid;
        abort_hit = i_abort && state != S_IDLE && state != S_DONE;
        // addr doubles as the delivered-word count
        last      = {1'b0, addr} == len_q - (ADDR_W + 1)'(1);
        nxt       = state;
        case (state)
            S_IDLE:    nxt = i_cmd_valid ? (cmd_bad ? S_DONE : S_ARM) : S_IDLE;
            S_ARM:     nxt = S_CAPTURE;
            S_CAPTURE: nxt = cnt == CAP_LAST ? S_READ : S_CAPTURE;
            S_READ:    nxt = S_WAIT;
            S_WAIT:    nxt = cnt == LAT_LAST ? S_OUT : S_WAIT;
            S_OUT:     nxt = i_ready ? (last ? S_DONE : S_READ) : S_OUT;
            default:   nxt = S_IDLE;
        endcase
        if (abort_hit) nxt = S_DONE;
        o_cmd_ready        = state == S_IDLE;
        o_busy             = state != S_IDLE;
        o_en_write         = state == S_ARM;
        o_en_read          = rd_q;
        o_read_adrs        = addr;
        o_valid            = state == S_OUT;
        o_done             = state == S_DONE;
        o_err              = state == S_DONE && err_q;
        o_data_sel_for_log = state != S_IDLE ? sel_q : 3'd0;
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr   <= '0;
            len_q  <= '0;
            sel_q  <= '0;
            err_q  <= 1'b0;
            rd_q   <= 1'b0;
            o_data <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt == state && (state == S_CAPTURE || state == S_WAIT)) ? cnt + CNT_W'(1) : '0;
            if (accept) begin
                sel_q <= i_cmd_sel;
                len_q <= i_cmd_len > DEPTH_L ? DEPTH_L : i_cmd_len;
            end
            err_q <= accept ? cmd_bad : abort_hit ? 1'b1 : state == S_DONE ? 1'b0 : err_q;
            // read enable held from the first READ until DONE exits so the logger stays frozen
            rd_q  <= nxt == S_READ ? 1'b1 : state == S_DONE ? 1'b0 : rd_q;
            addr  <= state == S_IDLE ? '0 :
                     (state == S_OUT && i_ready && !i_abort && !last) ? addr + ADDR_W'(1) : addr;
            if (state == S_WAIT && cnt == LAT_LAST) o_data <= i_ram_data;
        end
    end
endmodule

// File: tb/tb_log_readout_sequencer.sv
// tb_log_readout_sequencer: directed and randomized commands checked against a behavioural model.
module tb_log_readout_sequencer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 8;
    localparam int RL    = 1;

    logic          clk = 0;
    logic          i_reset = 0;
    logic          i_cmd_valid = 0;
    logic          o_cmd_ready;
    logic [2:0]    i_cmd_sel = 0;
    logic [AW:0]   i_cmd_len = 0;
    logic          i_abort = 0;
    logic [2:0]    o_data_sel_for_log;
    logic          o_en_write, o_en_read;
    logic [AW-1:0] o_read_adrs;
    logic [31:0]   i_ram_data;
    logic [31:0]   o_data;
    logic          o_valid;
    logic          i_ready = 0;
    logic          o_busy, o_done, o_err;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   ram_q = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ram_q <= mem[o_read_adrs];
    assign i_ram_data = ram_q;

    log_readout_sequencer #(.RAM_WIDTH(32), .RAM_DEPTH(DEPTH), .READ_LATENCY(RL), .CAPTURE_WAIT(CW)) dut (
        .clk(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_sel(i_cmd_sel), .i_cmd_len(i_cmd_len), .i_abort(i_abort),
        .o_data_sel_for_log(o_data_sel_for_log), .o_en_write(o_en_write), .o_en_read(o_en_read),
        .o_read_adrs(o_read_adrs), .i_ram_data(i_ram_data), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One command from accept to done; model: words mem[0..n-1] in order, done at
    // CW+1 + n*(RL+2) + stall cycles after the accept edge, or one cycle after an abort.
    task automatic run_cmd(input logic [2:0] sel, input logic [AW:0] len, input int ready_pct,
                           input int stall0, input int abort_at);
        int n, c_done, words, stalls, first_rd, rd_cnt, wr_cnt, both, sel_bad, abort_c, stall_left;
        logic bad, aborting, err_seen;
        bad        = !(sel >= 3'd1 && sel <= 3'd3) || len == 0;
        n          = bad ? 0 : (int'(len) > DEPTH ? DEPTH : int'(len));
        aborting   = !bad && abort_at >= 0 && abort_at < n;
        c_done     = -1; words = 0; stalls = 0; first_rd = -1; rd_cnt = 0; wr_cnt = 0;
        both       = 0; sel_bad = 0; abort_c = -1; stall_left = stall0; err_seen = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        @(negedge clk);
        i_cmd_valid = 1; i_cmd_sel = sel; i_cmd_len = len;
        for (int c = 0; c < 2000 && c_done < 0; c++) begin
            @(negedge clk);
            i_abort = 0;
            if (c == 0) chk("busy_after_accept", o_busy, 1);
            if (o_en_write) wr_cnt++;
            if (!bad && o_data_sel_for_log !== sel) sel_bad++;
            if (o_en_read) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = c;
            end
            if (o_valid && o_done) both++;
            if (o_done) begin
                c_done   = c;
                err_seen = o_err;
            end
            if (o_valid) begin
                chk("word_data", o_data, mem[words % DEPTH]);
                chk("word_addr", o_read_adrs, 64'(words));
                if (words == abort_at) begin
                    i_abort = 1; i_ready = 1; abort_c = c;
                end else if (stall_left > 0) begin
                    i_ready = 0; stall_left--;
                end else i_ready = $urandom_range(99) < ready_pct;
                if (!i_ready) stalls++;
                if (i_ready && !i_abort) words++;
            end else i_ready = $urandom_range(1);
            // commands presented while busy must be ignored
            i_cmd_valid = o_done ? 1'b0 : 1'($urandom_range(1));
        end
        i_cmd_valid = 0; i_abort = 0;
        chk("done_seen", c_done >= 0, 1);
        chk("done_err", err_seen, bad || aborting);
        chk("words_delivered", words, aborting ? abort_at : n);
        chk("write_pulses", wr_cnt, bad ? 0 : 1);
        chk("first_read_cycle", first_rd, bad ? -1 : CW + 1);
        chk("read_cycles", rd_cnt, bad ? 0 : c_done - CW);
        chk("done_cycle", c_done, bad ? 0 : aborting ? abort_c + 1 : CW + 1 + n * (RL + 2) + stalls);
        chk("valid_and_done", both, 0);
        chk("sel_stable", sel_bad, 0);
        @(negedge clk);
        chk("ready_after_done", o_cmd_ready, 1);
        chk("no_done_after", o_done, 0);
        chk("read_off_after", o_en_read, 0);
        chk("sel_idle", o_data_sel_for_log, 0);
    endtask

    initial begin
        int dn;
        for (int i = 0; i < DEPTH; i++) mem[i] = 0;
        @(negedge clk);
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_en_write", o_en_write, 0);
        chk("rst_en_read", o_en_read, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_done", o_done, 0);
        chk("rst_adrs", o_read_adrs, 0);
        chk("rst_sel", o_data_sel_for_log, 0);
        chk("rst_data", o_data, 0);
        i_reset = 1;
        @(negedge clk);
        // basic run, ready tied high
        run_cmd(3'd1, 5'd4, 100, 0, -1);
        // first word held off for 5 cycles
        run_cmd(3'd3, 5'd2, 100, 5, -1);
        // invalid commands
        run_cmd(3'b100, 5'd4, 100, 0, -1);
        run_cmd(3'd0, 5'd3, 100, 0, -1);
        run_cmd(3'd2, 5'd0, 100, 0, -1);
        // length clamped to the RAM depth
        run_cmd(3'd2, 5'(DEPTH + 5), 100, 0, -1);
        // abort in OUT together with ready
        run_cmd(3'd1, 5'd4, 100, 0, 2);
        run_cmd(3'd3, 5'd3, 100, 0, 0);
        // reset during capture
        @(negedge clk);
        i_cmd_valid = 1; i_cmd_sel = 3'd2; i_cmd_len = 5'd3;
        @(negedge clk);
        i_cmd_valid = 0;
        repeat (3) @(negedge clk);
        chk("cap_busy", o_busy, 1);
        i_reset = 0;
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_cmd_ready", o_cmd_ready, 1);
        chk("arst_en_read", o_en_read, 0);
        chk("arst_en_write", o_en_write, 0);
        chk("arst_valid", o_valid, 0);
        chk("arst_sel", o_data_sel_for_log, 0);
        chk("arst_adrs", o_read_adrs, 0);
        chk("arst_data", o_data, 0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_done) dn++;
        end
        i_reset = 1;
        repeat (3) begin
            @(negedge clk);
            if (o_done || o_busy) dn++;
        end
        chk("arst_no_done", dn, 0);
        run_cmd(3'd2, 5'd3, 100, 0, -1);
        // randomized commands
        repeat (8) run_cmd(3'($urandom_range(1, 3)), 5'($urandom_range(1, DEPTH + 3)), 60, 0, -1);
        repeat (3) run_cmd(3'($urandom_range(1, 3)), 5'($urandom_range(2, DEPTH)), 70, 0, $urandom_range(0, 1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
